// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared types and constants for the 4K x 32 SRAM request controller
package sram_ctrl_pkg;

  localparam int SRAM_AW    = 12;
  localparam int SRAM_DW    = 32;
  localparam int SRAM_DEPTH = 4096;
  localparam int SRAM_NB    = SRAM_DW / 8;

  localparam logic [3:0] BE_FULL = 4'hF;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    MERGE
  } sram_state_e;

endpackage

// File: rtl/sram_byte_merge.sv
// rtl/sram_byte_merge.sv - combinational byte-lane merge of new data over an old word
module sram_byte_merge #(
  parameter int NB = 4
) (
  input  logic [8*NB-1:0] old_data,
  input  logic [8*NB-1:0] new_data,
  input  logic [NB-1:0]   be,
  output logic [8*NB-1:0] merged
);

  always_comb begin
    merged = old_data;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) merged[8*i +: 8] = new_data[8*i +: 8];
    end
  end

endmodule

// File: rtl/sram_rmw_ctrl.sv
// rtl/sram_rmw_ctrl.sv - SRAM request controller with read-modify-write for partial stores
// Optional zero-fill sweep after reset is built when SRAM_RMW_INIT_EN is defined.
module sram_rmw_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int          AW       = SRAM_AW,
  parameter int          DW       = SRAM_DW,
  parameter logic [31:0] INIT_VAL = 32'h0
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [3:0]    req_be,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          init_done,
  output logic [AW-1:0] sram_waddr,
  output logic [DW-1:0] sram_wd,
  output logic          sram_wen,
  output logic [AW-1:0] sram_raddr,
  input  logic [DW-1:0] sram_rd
);

`ifdef SRAM_RMW_INIT_EN
  localparam sram_state_e RST_STATE = INIT;
`else
  localparam sram_state_e RST_STATE = IDLE;
`endif

  sram_state_e   state, state_n;
  logic [AW-1:0] cap_addr;
  logic [3:0]    cap_be;
  logic [DW-1:0] cap_wdata;
  logic [AW-1:0] raddr_q;
  logic [DW-1:0] merged;
  logic          rd_acc;
  logic          cap_en;

`ifdef SRAM_RMW_INIT_EN
  logic [AW-1:0] cnt;
  logic          init_done_q;
`endif

  // During MERGE the read port still presents the captured address, so sram_rd is the old word.
  sram_byte_merge #(.NB(4)) u_merge (
    .old_data(sram_rd),
    .new_data(cap_wdata),
    .be      (cap_be),
    .merged  (merged)
  );

  assign rsp_rdata = sram_rd;

  always_comb begin
    state_n    = state;
    req_ready  = 1'b0;
    sram_wen   = 1'b0;
    sram_waddr = cap_addr;
    sram_wd    = merged;
    sram_raddr = raddr_q;
    rd_acc     = 1'b0;
    cap_en     = 1'b0;
    case (state)
      INIT: begin
        sram_wd = INIT_VAL;
`ifdef SRAM_RMW_INIT_EN
        sram_wen   = 1'b1;
        sram_waddr = cnt;
        if (cnt == AW'(SRAM_DEPTH - 1)) state_n = IDLE;
`else
        state_n = IDLE;
`endif
      end
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (!req_we) begin
            sram_raddr = req_addr;
            rd_acc     = 1'b1;
          end else if (req_be == BE_FULL) begin
            sram_wen   = 1'b1;
            sram_waddr = req_addr;
            sram_wd    = req_wdata;
          end else if (req_be != 4'h0) begin
            sram_raddr = req_addr;
            cap_en     = 1'b1;
            state_n    = MERGE;
          end
        end
      end
      MERGE: begin
        sram_wen = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Reset masks the write strobe immediately so an interrupted RMW leaves the old word intact.
    if (!RSTN) begin
      req_ready = 1'b0;
      sram_wen  = 1'b0;
      rd_acc    = 1'b0;
      cap_en    = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state     <= RST_STATE;
      rsp_valid <= 1'b0;
      cap_addr  <= '0;
      cap_be    <= '0;
      cap_wdata <= '0;
      raddr_q   <= '0;
    end else begin
      state     <= state_n;
      rsp_valid <= rd_acc;
      raddr_q   <= sram_raddr;
      if (cap_en) begin
        cap_addr  <= req_addr;
        cap_be    <= req_be;
        cap_wdata <= req_wdata;
      end
    end
  end

`ifdef SRAM_RMW_INIT_EN
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      cnt         <= '0;
      init_done_q <= 1'b0;
    end else begin
      if (state == INIT) cnt <= cnt + 1'b1;
      if (state == INIT && state_n == IDLE) init_done_q <= 1'b1;
    end
  end

  assign init_done = init_done_q;
`else
  assign init_done = 1'b1;
`endif

endmodule
